// File: rtl/lc3_mem_responder_if.sv
// Bus between the LC-3 datapath (master) and the memory responder (slave).
// Handshake: the master raises MEM_EN and holds it, with MAR/MDR/WE stable,
// until R pulses; R is a single-cycle ready strobe, and the master must drop
// MEM_EN before a new access can be accepted.
interface lc3_mem_responder_if;
    logic        MEM_EN;
    logic        WE;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] MDR_In;
    logic        R;
    logic [15:0] SW;
    logic [15:0] HEX_OUT;

    modport master (
        output MEM_EN, WE, MAR, MDR, SW,
        input  MDR_In, R, HEX_OUT
    );

    modport slave (
        input  MEM_EN, WE, MAR, MDR, SW,
        output MDR_In, R, HEX_OUT
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// Wait-stated 16-bit RAM responder for an LC-3 datapath.
// Define LC3_MMIO_HEX_EN to map address 16'hFFFF to SW (read) / HEX_OUT (write).
module lc3_mem_responder #(
    parameter int AW          = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    lc3_mem_responder_if.slave bus,
    output logic [1:0]         dbg_state_o
);
    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    // Encoding is visible on dbg_state_o: IDLE=0, WAIT=1, DONE=2, HOLD=3.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        r_q;
    logic [15:0] mdr_in_q;
    logic [15:0] ram_q [DEPTH];

    logic [AW-1:0] idx;
    logic          is_mmio;
    logic [15:0]   rd_data;
    logic          ram_we;

    assign idx = addr_q[AW-1:0];

`ifdef LC3_MMIO_HEX_EN
    logic [15:0] hex_q;

    assign is_mmio     = (addr_q == 16'hFFFF);
    assign rd_data     = is_mmio ? bus.SW : ram_q[idx];
    assign bus.HEX_OUT = hex_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hex_q <= 16'h0000;
        end else if (state_q == DONE && we_q && is_mmio) begin
            hex_q <= wdata_q;
        end
    end
`else
    logic unused_bits;

    assign is_mmio     = 1'b0;
    assign rd_data     = ram_q[idx];
    assign bus.HEX_OUT = 16'h0000;
    // Switches and the aliased upper address bits have no consumer here.
    assign unused_bits = ^{bus.SW, addr_q};
`endif

    assign ram_we = (state_q == DONE) && we_q && !is_mmio;

    // RAM has no reset so its contents survive Reset.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            ram_q[idx] <= wdata_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            r_q      <= 1'b0;
            mdr_in_q <= 16'h0000;
        end else begin
            r_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.MEM_EN) begin
                        addr_q  <= bus.MAR;
                        wdata_q <= bus.MDR;
                        we_q    <= bus.WE;
                        cnt_q   <= WS4;
                        state_q <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.MEM_EN) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_q <= 1'b1;
                    if (!we_q) begin
                        mdr_in_q <= rd_data;
                    end
                    state_q <= HOLD;
                end
                HOLD: begin
                    // One held request yields one access; wait for MEM_EN to fall.
                    if (!bus.MEM_EN) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.R       = r_q;
    assign bus.MDR_In  = mdr_in_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_lc3_mem_responder;
  localparam int WS = 2;

  logic Clk;
  logic Reset;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state0;

  lc3_mem_responder_if bus ();
  lc3_mem_responder_if bus0 ();

  lc3_mem_responder #(.AW(8), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .dbg_state_o(dbg_state)
  );

  lc3_mem_responder #(.AW(8), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(bus0), .dbg_state_o(dbg_state0)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int r_count = 0;
  logic [15:0] exp_q[$];
  logic [15:0] ram_m [256];
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] hex_m = 16'h0000;

  always @(negedge Clk) if (bus.R === 1'b1) r_count++;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: writes land in ram_m (or HEX with MMIO), reads return
  // the stored word, and MDR_In keeps the last read value across writes.
  function automatic logic [15:0] model_access(input bit we, input logic [15:0] addr,
                                               input logic [15:0] data);
    bit mmio;
`ifdef LC3_MMIO_HEX_EN
    mmio = (addr == 16'hFFFF);
`else
    mmio = 1'b0;
`endif
    if (we) begin
      if (mmio) hex_m = data;
      else ram_m[addr[7:0]] = data;
    end else begin
      last_rd = mmio ? bus.SW : ram_m[addr[7:0]];
    end
    return last_rd;
  endfunction

  // driver: one full access on the WS=2 instance
  task automatic do_access(input bit we, input logic [15:0] addr, input logic [15:0] data,
                           input int hold, output int lat, output logic [15:0] rd);
    bit seen;
    @(negedge Clk);
    bus.MEM_EN = 1'b1; bus.WE = we; bus.MAR = addr; bus.MDR = data;
    @(posedge Clk);
    #1;
    bus.MAR = 16'($urandom); bus.MDR = 16'($urandom); bus.WE = 1'($urandom_range(0, 1));
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (bus.R === 1'b1) seen = 1'b1;
    end
    if (!seen) lat = 99;
    rd = bus.MDR_In;
    @(posedge Clk); #1;
    check("r_width", {15'd0, bus.R}, 16'h0000);
    repeat (hold) @(posedge Clk);
    @(negedge Clk);
    bus.MEM_EN = 1'b0;
    @(negedge Clk);
  endtask

  task automatic access0(input bit we, input logic [15:0] addr, input logic [15:0] data,
                         output int lat, output logic [15:0] rd);
    bit seen;
    @(negedge Clk);
    bus0.MEM_EN = 1'b1; bus0.WE = we; bus0.MAR = addr; bus0.MDR = data;
    @(posedge Clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (bus0.R === 1'b1) seen = 1'b1;
    end
    if (!seen) lat = 99;
    rd = bus0.MDR_In;
    @(negedge Clk);
    bus0.MEM_EN = 1'b0;
    @(negedge Clk);
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int rc;
    logic [15:0] rd;
    logic [15:0] exp;

    vecs[0] = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0012, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 16'h0112, 16'h1111, 16'hBEEF};
    vecs[3] = '{1'b0, 16'h0012, 16'h0000, 16'h1111};
    vecs[4] = '{1'b1, 16'h0005, 16'h5555, 16'h1111};
    vecs[5] = '{1'b0, 16'h0005, 16'h0000, 16'h5555};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h00A5, 16'h5555};
`ifdef LC3_MMIO_HEX_EN
    vecs[7] = '{1'b0, 16'hFFFF, 16'h0000, 16'h3C3C};
`else
    vecs[7] = '{1'b0, 16'h00FF, 16'h0000, 16'h00A5};
`endif

    Reset = 1'b1;
    bus.MEM_EN = 1'b0; bus.WE = 1'b0; bus.MAR = 16'h0; bus.MDR = 16'h0; bus.SW = 16'h3C3C;
    bus0.MEM_EN = 1'b0; bus0.WE = 1'b0; bus0.MAR = 16'h0; bus0.MDR = 16'h0; bus0.SW = 16'h0;
    repeat (3) @(negedge Clk);
    check("rst_r", {15'd0, bus.R}, 16'h0000);
    check("rst_mdr_in", bus.MDR_In, 16'h0000);
    check("rst_hex", bus.HEX_OUT, 16'h0000);
    check("rst_state", {14'd0, dbg_state}, 16'h0000);
    Reset = 1'b0;
    @(negedge Clk);

    // directed table
    for (int i = 0; i < 8; i++) begin
      exp = model_access(vecs[i].we, vecs[i].addr, vecs[i].data);
      do_access(vecs[i].we, vecs[i].addr, vecs[i].data, 0, lat, rd);
      check($sformatf("vec%0d_lat", i), 16'(lat), 16'(WS + 1));
      check($sformatf("vec%0d_mdr_in", i), rd, vecs[i].exp_rd);
      if (i == 6) begin
`ifdef LC3_MMIO_HEX_EN
        check("hex_write", bus.HEX_OUT, 16'h00A5);
`else
        check("hex_tied", bus.HEX_OUT, 16'h0000);
`endif
      end
    end

    // held request: one pulse over 10 extra held cycles, then a fresh access
    rc = r_count;
    exp = model_access(1'b0, 16'h0012, 16'h0);
    do_access(1'b0, 16'h0012, 16'h0, 10, lat, rd);
    check("held_pulses", 16'(r_count - rc), 16'd1);
    check("held_rd", rd, exp);
    exp = model_access(1'b0, 16'h0005, 16'h0);
    do_access(1'b0, 16'h0005, 16'h0, 0, lat, rd);
    check("reraise_lat", 16'(lat), 16'(WS + 1));
    check("reraise_rd", rd, exp);

    // abort during WAIT
    rc = r_count;
    @(negedge Clk);
    bus.MEM_EN = 1'b1; bus.WE = 1'b1; bus.MAR = 16'h0005; bus.MDR = 16'h1234;
    @(posedge Clk);
    @(negedge Clk);
    bus.MEM_EN = 1'b0;
    repeat (5) @(negedge Clk);
    check("abort_no_r", 16'(r_count - rc), 16'd0);
    check("abort_state", {14'd0, dbg_state}, 16'h0000);
    exp = model_access(1'b0, 16'h0005, 16'h0);
    do_access(1'b0, 16'h0005, 16'h0, 0, lat, rd);
    check("abort_old_val", rd, 16'h5555);

    // reset in the middle of a write
    exp = model_access(1'b1, 16'h0030, 16'hAAAA);
    do_access(1'b1, 16'h0030, 16'hAAAA, 0, lat, rd);
    @(negedge Clk);
    bus.MEM_EN = 1'b1; bus.WE = 1'b1; bus.MAR = 16'h0030; bus.MDR = 16'hDEAD;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("midrst_r", {15'd0, bus.R}, 16'h0000);
    check("midrst_mdr_in", bus.MDR_In, 16'h0000);
    check("midrst_state", {14'd0, dbg_state}, 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;
    bus.MEM_EN = 1'b0;
    last_rd = 16'h0000;
    @(negedge Clk);
    exp = model_access(1'b0, 16'h0030, 16'h0);
    do_access(1'b0, 16'h0030, 16'h0, 0, lat, rd);
    check("midrst_keep", rd, 16'hAAAA);
    exp = model_access(1'b0, 16'h0005, 16'h0);
    do_access(1'b0, 16'h0005, 16'h0, 0, lat, rd);
    check("rst_survive", rd, exp);

    // zero wait states
    access0(1'b1, 16'h0001, 16'h7777, lat, rd);
    check("ws0_wr_lat", 16'(lat), 16'd1);
    access0(1'b0, 16'h0001, 16'h0000, lat, rd);
    check("ws0_rd_lat", 16'(lat), 16'd1);
    check("ws0_rd", rd, 16'h7777);

    // randomized traffic against the model, aliases included
    for (int k = 0; k < 16; k++) begin
      logic [15:0] a;
      a = {8'($urandom_range(0, 255)), 8'(8'h40 + k)};
      exp = model_access(1'b1, a, 16'($urandom));
      do_access(1'b1, a, ram_m[a[7:0]], 0, lat, rd);
    end
    for (int k = 0; k < 40; k++) begin
      bit we;
      logic [15:0] a;
      logic [15:0] d;
      we = 1'($urandom_range(0, 1));
      a = {8'($urandom_range(0, 255)), 8'(8'h40 + $urandom_range(0, 15))};
      d = 16'($urandom);
      exp_q.push_back(model_access(we, a, d));
      do_access(we, a, d, $urandom_range(0, 3), lat, rd);
      check($sformatf("rnd%0d_lat", k), 16'(lat), 16'(WS + 1));
      check($sformatf("rnd%0d_mdr_in", k), rd, exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
